// File: rtl/cla_16_bit_lac_pkg.sv
// Shared constants and the registered-result record for the 16-bit
// two-level carry-lookahead adder.
package cla_16_bit_lac_pkg;

    localparam int WIDTH = 16;
    localparam int BLK   = 4;
    localparam int NBLK  = WIDTH / BLK;

    typedef struct packed {
        logic             c_out;
        logic             p;
        logic             g;
        logic [WIDTH-1:0] sum;
    } cla_res_t;

endpackage

// File: rtl/cla_16_bit_lac_cla_4_bit_block.sv
// 4-bit carry-lookahead block: full lookahead internal carries, block
// propagate/generate for the second-level lookahead unit.
module cla_4_bit_block
    import cla_16_bit_lac_pkg::*;
(
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           cin,
    output logic [BLK-1:0] s,
    output logic           Pk,
    output logic           Gk
);

    logic [BLK-1:0] p;
    logic [BLK-1:0] g;
    logic [BLK-1:0] c;

    assign p = a ^ b;
    assign g = a & b;

    // Every carry is expanded from cin directly so no carry ripples.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);

    assign s  = p ^ c;
    assign Pk = &p;
    assign Gk = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/cla_16_bit_lac.sv
// 16-bit two-level carry-lookahead adder: four 4-bit CLA blocks, a
// lookahead carry unit, and a single output register stage.
module cla_16_bit_lac
    import cla_16_bit_lac_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             P,
    output logic             G
);

    logic [NBLK-1:0]  blk_p;
    logic [NBLK-1:0]  blk_g;
    logic [NBLK-1:0]  blk_c;
    logic [WIDTH-1:0] sum_w;
    logic             grp_p;
    logic             grp_g;
    cla_res_t         res_d;
    cla_res_t         res_q;

    for (genvar k = 0; k < NBLK; k++) begin : g_blk
        cla_4_bit_block u_blk (
            .a   (a[k*BLK +: BLK]),
            .b   (b[k*BLK +: BLK]),
            .cin (blk_c[k]),
            .s   (sum_w[k*BLK +: BLK]),
            .Pk  (blk_p[k]),
            .Gk  (blk_g[k])
        );
    end

    // Lookahead carry unit: block carries all derive from c_in.
    assign blk_c[0] = c_in;
    assign blk_c[1] = blk_g[0] | (blk_p[0] & c_in);
    assign blk_c[2] = blk_g[1] | (blk_p[1] & blk_g[0])
                    | (blk_p[1] & blk_p[0] & c_in);
    assign blk_c[3] = blk_g[2] | (blk_p[2] & blk_g[1])
                    | (blk_p[2] & blk_p[1] & blk_g[0])
                    | (blk_p[2] & blk_p[1] & blk_p[0] & c_in);

    assign grp_p = &blk_p;
    assign grp_g = blk_g[3] | (blk_p[3] & blk_g[2])
                 | (blk_p[3] & blk_p[2] & blk_g[1])
                 | (blk_p[3] & blk_p[2] & blk_p[1] & blk_g[0]);

    always_comb begin
        res_d       = '0;
        res_d.sum   = sum_w;
        res_d.p     = grp_p;
        res_d.g     = grp_g;
        res_d.c_out = grp_g | (grp_p & c_in);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
        end else begin
            res_q <= res_d;
        end
    end

    assign sum   = res_q.sum;
    assign c_out = res_q.c_out;
    assign P     = res_q.p;
    assign G     = res_q.g;

endmodule

// File: tb/tb_cla_16_bit_lac.sv
// Randomised self-checking bench for cla_16_bit_lac against a plain
// integer-arithmetic reference model.
module tb_cla_16_bit_lac;

    logic        clk;
    logic        rst_n;
    logic [15:0] a;
    logic [15:0] b;
    logic        c_in;
    logic [15:0] sum;
    logic        c_out;
    logic        P;
    logic        G;

    int n_chk;
    int n_pass;

    cla_16_bit_lac dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .sum   (sum),
        .c_out (c_out),
        .P     (P),
        .G     (G)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Reference: sum/c_out from integer addition; P means every bit pair
    // propagates; G means a+b overflows even with no carry in.
    task automatic check_out(input string tag, input logic [15:0] ta,
                             input logic [15:0] tb_, input logic tc);
        int unsigned full;
        int unsigned nocin;
        full  = int'(ta) + int'(tb_) + int'(tc);
        nocin = int'(ta) + int'(tb_);
        chk({tag, ".sum"},   32'(sum),   full & 32'hFFFF);
        chk({tag, ".c_out"}, 32'(c_out), (full >> 16) & 1);
        chk({tag, ".P"},     32'(P),     32'((ta ^ tb_) == 16'hFFFF));
        chk({tag, ".G"},     32'(G),     (nocin >> 16) & 1);
    endtask

    task automatic apply(input string tag, input logic [15:0] ta,
                         input logic [15:0] tb_, input logic tc);
        @(negedge clk);
        a    = ta;
        b    = tb_;
        c_in = tc;
        @(posedge clk);
        #1;
        check_out(tag, ta, tb_, tc);
    endtask

    task automatic expect_lit(input string tag, input logic [15:0] es,
                              input logic ec, input logic ep, input logic eg);
        chk({tag, ".lit_sum"},   32'(sum),   32'(es));
        chk({tag, ".lit_c_out"}, 32'(c_out), 32'(ec));
        chk({tag, ".lit_P"},     32'(P),     32'(ep));
        chk({tag, ".lit_G"},     32'(G),     32'(eg));
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst_n  = 1'b0;
        a      = 16'h0;
        b      = 16'h0;
        c_in   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Load something nonzero, then assert reset away from any edge.
        apply("preload", 16'hFFFF, 16'h0001, 1'b1);
        #2;
        a     = 16'h1234;
        b     = 16'h4321;
        c_in  = 1'b1;
        rst_n = 1'b0;
        #1;
        expect_lit("async_rst", 16'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        expect_lit("rst_hold", 16'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_out("rst_release", 16'h1234, 16'h4321, 1'b1);

        apply("t1130", 16'd1130, 16'd0, 1'b0);
        expect_lit("t1130", 16'd1130, 1'b0, 1'b0, 1'b0);
        apply("tmsb", 16'd32768, 16'd32768, 1'b1);
        expect_lit("tmsb", 16'd1, 1'b1, 1'b0, 1'b1);
        apply("tprop", 16'd25000, 16'd40535, 1'b0);
        expect_lit("tprop", 16'd65535, 1'b0, 1'b1, 1'b0);
        apply("tgen", 16'd25001, 16'd40535, 1'b0);
        expect_lit("tgen", 16'd0, 1'b1, 1'b0, 1'b1);
        apply("tchain", 16'd65535, 16'd0, 1'b1);
        expect_lit("tchain", 16'd0, 1'b1, 1'b1, 1'b0);
        apply("tchain0", 16'd0, 16'd65535, 1'b0);
        apply("tmax", 16'hFFFF, 16'hFFFF, 1'b1);

        // Reset asserted mid-stream drops the in-flight result.
        @(negedge clk);
        a     = 16'hAAAA;
        b     = 16'h5555;
        c_in  = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        expect_lit("rst_mid", 16'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back random operands, one new vector every cycle; some
        // vectors are forced into the all-propagate case.
        for (int i = 0; i < 10000; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            logic        rc;
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            if ((i % 16) == 3) rb = ~ra;
            apply("rand", ra, rb, rc);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
